// File: rtl/qdi_rx_pkg.sv
// Shared types and helpers for the e1of1 QDI-to-binary receiver.
package qdi_rx_pkg;

   typedef enum logic [1:0] {
      NEUTRAL = 2'd0,
      READY   = 2'd1,
      ACK     = 2'd2,
      FULL    = 2'd3
   } rx_state_t;

   localparam logic SYNC_RESET_VAL = 1'b1;

   // Width needed to hold a count from 0 to depth inclusive.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/qdi_sync.sv
// Multi-flop synchronizer for one asynchronous bit; resets to SYNC_RESET_VAL
// so an unknown rail reads as non-neutral until its real level arrives.
module qdi_sync
   import qdi_rx_pkg::*;
#(
   parameter int unsigned STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_chain <= {STAGES{SYNC_RESET_VAL}};
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/qdi2bin_1of1_rx.sv
// Clocked receiver for an e1of1 QDI channel: four-phase handshake on L/Le,
// tokens buffered as a count and popped through tok_valid/tok_ready.
// Optional lifetime token counter on tok_total: QDI_RX_TOTAL_CNT_EN.
module qdi2bin_1of1_rx
   import qdi_rx_pkg::*;
#(
   parameter  int unsigned DEPTH       = 4,
   parameter  int unsigned SYNC_STAGES = 2,
   localparam int unsigned CNT_W       = cnt_w(DEPTH)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             L,
   output logic             Le,
   output logic             tok_valid,
   input  logic             tok_ready,
   output logic [CNT_W-1:0] pending,
   output logic             proto_err,
   output logic [31:0]      tok_total,
   inout  wire              VDD,
   inout  wire              GND
);

   logic w_unused_supply;
   assign w_unused_supply = VDD ^ GND;

   logic             w_ls;
   rx_state_t        r_state;
   rx_state_t        w_state_nxt;
   logic             r_le;
   logic             w_le_nxt;
   logic             r_ls_q;
   logic             r_tok_valid;
   logic             w_tok_valid_nxt;
   logic             r_proto_err;
   logic             w_proto_err_nxt;
   logic [CNT_W-1:0] r_pending;
   logic [CNT_W-1:0] w_pend_pop;
   logic [CNT_W-1:0] w_pending_nxt;
   logic             w_pop;
   logic             w_inc;
   logic             w_rise;

   qdi_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk (CLK),
      .i_rst (RESET),
      .i_d   (L),
      .o_q   (w_ls)
   );

   assign w_pop      = r_tok_valid & tok_ready;
   assign w_rise     = w_ls & ~r_ls_q;
   assign w_pend_pop = r_pending - CNT_W'(w_pop);

   // Handshake FSM; a pop in the same cycle counts when choosing READY vs FULL.
   always_comb begin
      w_state_nxt     = r_state;
      w_le_nxt        = r_le;
      w_inc           = 1'b0;
      w_proto_err_nxt = r_proto_err;
      case (r_state)
         NEUTRAL: begin
            if (w_rise) begin
               w_proto_err_nxt = 1'b1;
            end else if (!w_ls) begin
               w_state_nxt = READY;
               w_le_nxt    = 1'b1;
            end
         end
         READY: begin
            if (w_ls) begin
               w_inc       = 1'b1;
               w_le_nxt    = 1'b0;
               w_state_nxt = ACK;
            end
         end
         ACK: begin
            if (!w_ls) begin
               if (w_pend_pop < CNT_W'(DEPTH)) begin
                  w_state_nxt = READY;
                  w_le_nxt    = 1'b1;
               end else begin
                  w_state_nxt = FULL;
               end
            end
         end
         FULL: begin
            if (w_rise) begin
               w_proto_err_nxt = 1'b1;
            end else if (w_pop) begin
               w_state_nxt = READY;
               w_le_nxt    = 1'b1;
            end
         end
         default: begin
            w_state_nxt = NEUTRAL;
            w_le_nxt    = 1'b0;
         end
      endcase
      w_pending_nxt   = w_pend_pop + CNT_W'(w_inc);
      w_tok_valid_nxt = (w_pending_nxt != '0);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state     <= NEUTRAL;
         r_le        <= 1'b0;
         r_ls_q      <= SYNC_RESET_VAL;
         r_tok_valid <= 1'b0;
         r_proto_err <= 1'b0;
         r_pending   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_le        <= w_le_nxt;
         r_ls_q      <= w_ls;
         r_tok_valid <= w_tok_valid_nxt;
         r_proto_err <= w_proto_err_nxt;
         r_pending   <= w_pending_nxt;
      end
   end

`ifdef QDI_RX_TOTAL_CNT_EN
   logic [31:0] r_tok_total;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_tok_total <= 32'd0;
      end else if (w_inc) begin
         r_tok_total <= r_tok_total + 32'd1;
      end
   end

   assign tok_total = r_tok_total;
`else
   assign tok_total = 32'd0;
`endif

   assign Le        = r_le;
   assign tok_valid = r_tok_valid;
   assign pending   = r_pending;
   assign proto_err = r_proto_err;

endmodule

// File: tb/tb_qdi2bin_1of1_rx.sv
// Directed bench for qdi2bin_1of1_rx with a pop scoreboard; expects
// tok_total to count only when QDI_RX_TOTAL_CNT_EN is defined.
module tb_qdi2bin_1of1_rx;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 3;

   logic             CLK = 1'b0;
   logic             RESET;
   logic             L;
   logic             tok_ready;
   logic             Le;
   logic             tok_valid;
   logic             proto_err;
   logic [CNT_W-1:0] pending;
   logic [31:0]      tok_total;
   wire              VDD = 1'b1;
   wire              GND = 1'b0;

   typedef struct {
      int unsigned pend;
      int unsigned total;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          streaming = 1'b0;
   int unsigned max_pend = 0;

   qdi2bin_1of1_rx #(
      .DEPTH       (DEPTH),
      .SYNC_STAGES (2)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .L         (L),
      .Le        (Le),
      .tok_valid (tok_valid),
      .tok_ready (tok_ready),
      .pending   (pending),
      .proto_err (proto_err),
      .tok_total (tok_total),
      .VDD       (VDD),
      .GND       (GND)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned exp_tot(input int unsigned k);
`ifdef QDI_RX_TOTAL_CNT_EN
      return k;
`else
      return 0;
`endif
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wait_le(input logic v, input string name);
      for (int i = 0; i < 40; i++) begin
         if (Le === v) break;
         tick();
      end
      check(name, 32'(Le), 32'(v));
   endtask

   task automatic send_token();
      wait_le(1'b1, "le_ready");
      L = 1'b1;
      wait_le(1'b0, "le_ack");
      L = 1'b0;
   endtask

   task automatic push_exp(input int unsigned p, input int unsigned t);
      exp_t e;
      e.pend  = p;
      e.total = t;
      sb_q.push_back(e);
   endtask

   // Scoreboard monitor: every pop handshake must match the next expectation.
   always @(negedge CLK) begin
      if (!RESET && tok_valid && tok_ready) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pop: got pop with pending=%0d, expected no pop", pending);
         end else begin
            mon_e = sb_q.pop_front();
            check("pop_pending", 32'(pending), 32'(mon_e.pend));
            check("pop_total", tok_total, 32'(mon_e.total));
         end
      end
      if (streaming && 32'(pending) > max_pend) max_pend = 32'(pending);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET     = 1'b1;
      L         = 1'b0;
      tok_ready = 1'b0;

      // Reset state, then release latency.
      tick(3);
      check("rst_le", 32'(Le), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_valid", 32'(tok_valid), 32'd0);
      check("rst_err", 32'(proto_err), 32'd0);
      check("rst_total", tok_total, 32'd0);
      RESET = 1'b0;
      tick(2);
      check("le_before_release_lat", 32'(Le), 32'd0);
      tick(1);
      check("le_release_lat", 32'(Le), 32'd1);
      check("pending_after_release", 32'(pending), 32'd0);
      check("err_after_release", 32'(proto_err), 32'd0);

      // One handshake with exact edge latencies.
      L = 1'b1;
      tick(2);
      check("le_before_fall", 32'(Le), 32'd1);
      tick(1);
      check("le_fall_lat", 32'(Le), 32'd0);
      check("pending_1", 32'(pending), 32'd1);
      check("valid_1", 32'(tok_valid), 32'd1);
      check("total_1", tok_total, 32'(exp_tot(1)));
      L = 1'b0;
      tick(2);
      check("le_before_rise", 32'(Le), 32'd0);
      tick(1);
      check("le_rise_lat", 32'(Le), 32'd1);

      // Fill to DEPTH.
      for (int k = 0; k < 3; k++) send_token();
      tick(5);
      check("full_pending", 32'(pending), 32'd4);
      check("full_le", 32'(Le), 32'd0);
      check("full_valid", 32'(tok_valid), 32'd1);
      tick(3);
      check("full_le_stays", 32'(Le), 32'd0);

      // Single pop out of FULL re-enables Le on the same edge.
      push_exp(4, exp_tot(4));
      tok_ready = 1'b1;
      tick(1);
      tok_ready = 1'b0;
      check("pop_from_full_pending", 32'(pending), 32'd3);
      check("pop_from_full_le", 32'(Le), 32'd1);

      // Fifth token accepted, back to FULL.
      send_token();
      tick(4);
      check("refill_pending", 32'(pending), 32'd4);
      check("refill_le", 32'(Le), 32'd0);
      check("refill_total", tok_total, 32'(exp_tot(5)));

      // Protocol violation while FULL.
      L = 1'b1;
      tick(4);
      check("err_set", 32'(proto_err), 32'd1);
      check("err_pending", 32'(pending), 32'd4);
      check("err_le", 32'(Le), 32'd0);
      L = 1'b0;
      tick(4);
      check("err_sticky", 32'(proto_err), 32'd1);
      check("err_pending_hold", 32'(pending), 32'd4);

      RESET = 1'b1;
      tick(2);
      check("rst2_err", 32'(proto_err), 32'd0);
      check("rst2_pending", 32'(pending), 32'd0);
      check("rst2_valid", 32'(tok_valid), 32'd0);
      check("rst2_total", tok_total, 32'd0);
      RESET = 1'b0;
      wait_le(1'b1, "le_after_rst2");

      // Continuous consumer: every token popped the cycle after it is counted.
      tok_ready = 1'b1;
      streaming = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         push_exp(1, exp_tot(k));
         send_token();
      end
      tick(6);
      streaming = 1'b0;
      tok_ready = 1'b0;
      check("stream_max_pending", max_pend, 32'd1);
      check("stream_pending_end", 32'(pending), 32'd0);
      check("stream_total", tok_total, 32'(exp_tot(10)));
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      // Reset in ACK with L held high: nothing counted until L returns low.
      wait_le(1'b1, "le_before_midrst");
      L = 1'b1;
      wait_le(1'b0, "le_midrst_ack");
      check("midrst_pending_before", 32'(pending), 32'd1);
      RESET = 1'b1;
      tick(2);
      RESET = 1'b0;
      tick(6);
      check("midrst_le_held", 32'(Le), 32'd0);
      check("midrst_pending", 32'(pending), 32'd0);
      check("midrst_valid", 32'(tok_valid), 32'd0);
      check("midrst_err", 32'(proto_err), 32'd0);
      L = 1'b0;
      wait_le(1'b1, "le_reenable");
      tick(2);
      check("midrst_pending_after", 32'(pending), 32'd0);
      check("midrst_total", tok_total, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
